// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the master FSM state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // IDLE -> (WR -> WB | RA -> RD) -> RSP -> IDLE
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WB   = 3'd2,
    ST_RA   = 3'd3,
    ST_RD   = 3'd4,
    ST_RSP  = 3'd5
  } mst_state_e;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R channels) with master and slave views.
// Latency: n/a (wires only).
// Backpressure: standard valid/ready on every channel.
// Ports: none; instantiate and connect the master modport to axi_lite_master.
interface axi_lite_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: one cmd in, one length-1 AXI transaction, one rsp out.
// Latency: bus valids one cycle after cmd accept; rsp 2 cycles after that against a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; rsp held stable until rsp_ready; every AXI valid held until its ready.
// Ports: clk, rst_n (async, active-low); cmd_* request (valid/ready); rsp_* response (valid/ready)
//        with echoed write flag, read data, BRESP/RRESP and saturating bus latency; m_axi master modport.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [LAT_WIDTH-1:0]    rsp_latency,

  axi_lite_master_if.master       m_axi
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  mst_state_e              state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q,   wstrb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q,  wvalid_d;
  logic                    write_q,   write_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
  logic [1:0]              resp_q,    resp_d;
  logic [LAT_WIDTH-1:0]    lat_q,     lat_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    lat_d     = lat_q;

    // Every edge spent waiting on the bus counts, including the edge that leaves it.
    if ((state_q == ST_WR) || (state_q == ST_WB) ||
        (state_q == ST_RA) || (state_q == ST_RD)) begin
      if (lat_q != {LAT_WIDTH{1'b1}}) begin
        lat_d = lat_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          lat_d   = '0;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            state_d   = ST_RA;
          end
        end
      end
      ST_WR: begin
        // AW and W retire independently; leave only once neither is outstanding.
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = ST_WB;
      end
      ST_WB: begin
        if (m_axi.bvalid) begin
          resp_d  = m_axi.bresp;
          rdata_d = '0;
          state_d = ST_RSP;
        end
      end
      ST_RA: begin
        if (m_axi.arready) state_d = ST_RD;
      end
      ST_RD: begin
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          resp_d  = m_axi.rresp;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      lat_q     <= lat_d;
    end
  end

  // Handshake outputs that track a single state are decoded from state_q.
  assign cmd_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_RSP);
  assign m_axi.bready  = (state_q == ST_WB);
  assign m_axi.arvalid = (state_q == ST_RA);
  assign m_axi.rready  = (state_q == ST_RD);

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;

  assign rsp_write   = write_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_latency = lat_q;

endmodule

// File: tb/tb_axi_lite_master.sv
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [LW-1:0] rsp_latency;

  always #5 clk = ~clk;

  axi_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAT_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
    .m_axi(bus.master)
  );

  int vectors = 0;
  int miscompares = 0;

  // Slave knobs and observation
  bit         aw_rdy = 1'b1;
  bit         ar_rdy = 1'b1;
  int         w_delay = 0;
  logic [1:0] b_resp_k = 2'b00;
  logic [1:0] r_resp_k = 2'b00;
  bit         r_force = 1'b0;
  logic [31:0] r_force_dat = '0;
  logic [31:0] mem [4];
  int cyc = 0;
  int aw_cyc = 0, w_cyc = 0, b_cyc = 0, ar_cyc = 0, r_cyc = 0;
  int hs_cnt = 0;
  int n_edge = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register-file slave: decisions made 1 time unit after each edge.
  initial begin : slave
    int         wcnt;
    bit         aw_seen, w_seen;
    logic [3:0] pend_addr, rd_addr;
    logic [31:0] pend_dat;
    logic [3:0] pend_strb;
    wcnt = 0; aw_seen = 0; w_seen = 0;
    pend_addr = '0; rd_addr = '0; pend_dat = '0; pend_strb = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b1; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        aw_seen = 0; w_seen = 0;
      end else begin
        if (bus.awvalid && bus.awready) begin aw_seen = 1; pend_addr = bus.awaddr; aw_cyc = cyc; hs_cnt++; end
        if (bus.wvalid && bus.wready) begin w_seen = 1; pend_dat = bus.wdata; pend_strb = bus.wstrb; w_cyc = cyc; hs_cnt++; end
        if (aw_seen && w_seen) begin
          for (int b = 0; b < 4; b++)
            if (pend_strb[b]) mem[pend_addr[3:2]][8*b +: 8] = pend_dat[8*b +: 8];
          aw_seen = 0; w_seen = 0;
        end
        if (bus.bvalid && bus.bready) begin b_cyc = cyc; hs_cnt++; end
        if (bus.arvalid && bus.arready) begin rd_addr = bus.araddr; ar_cyc = cyc; hs_cnt++; end
        if (bus.rvalid && bus.rready) begin r_cyc = cyc; hs_cnt++; end
      end
      #1;
      bus.awready = aw_rdy;
      wcnt = bus.wvalid ? wcnt + 1 : 0;
      bus.wready = (w_delay == 0) || (wcnt > w_delay);
      bus.bvalid = bus.bready;
      bus.bresp  = b_resp_k;
      bus.arready = ar_rdy;
      bus.rvalid = bus.rready;
      bus.rdata  = r_force ? r_force_dat : mem[rd_addr[3:2]];
      bus.rresp  = r_resp_k;
    end
  end

  task automatic issue(input bit w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    @(negedge clk);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_edge = cyc;
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (!rsp_valid && k < 1000) begin @(negedge clk); k++; end
    chk("rsp_arrives", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n_prev, hs_snap;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valids", {27'd0, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_fields", {21'd0, rsp_write, rsp_resp, rsp_latency}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_axi_addr_data", {24'd0, bus.awaddr, bus.wstrb}, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    rst_n = 1'b1;

    // 1: write 0x4 <= DEADBEEF, zero-wait slave
    issue(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
    chk("wr_valids_after_accept", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    chk("wr_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    chk("wr_awaddr", {28'd0, bus.awaddr}, 32'h4);
    wait_rsp();
    chk("wr_rsp_edge", cyc - n_edge, 32'd2);
    chk("wr_aw_edge", aw_cyc - n_edge, 32'd1);
    chk("wr_w_edge", w_cyc - n_edge, 32'd1);
    chk("wr_b_edge", b_cyc - n_edge, 32'd2);
    chk("wr_resp", {30'd0, rsp_resp}, 32'd0);
    chk("wr_rsp_write", {31'd0, rsp_write}, 32'd1);
    chk("wr_latency", {24'd0, rsp_latency}, 32'd2);
    chk("wr_rdata_zero", rsp_rdata, 32'd0);
    n_prev = n_edge;

    // 2: read back 0x4, back-to-back
    issue(1'b0, 4'h4, 32'h0, 4'h0);
    chk("cmd_spacing", n_edge - n_prev, 32'd4);
    chk("rd_arvalid", {29'd0, bus.arvalid, bus.awvalid, bus.wvalid}, 32'h4);
    wait_rsp();
    chk("rd_ar_edge", ar_cyc - n_edge, 32'd1);
    chk("rd_r_edge", r_cyc - n_edge, 32'd2);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_resp", {30'd0, rsp_resp}, 32'd0);
    chk("rd_latency", {24'd0, rsp_latency}, 32'd2);
    chk("rd_rsp_write", {31'd0, rsp_write}, 32'd0);

    // 3: wready 3 cycles behind awready
    w_delay = 3;
    issue(1'b1, 4'h8, 32'hA5A50001, 4'h3);
    chk("wd_valids_start", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wd_aw_dropped", {31'd0, bus.awvalid}, 32'd0);
      chk("wd_w_held", {31'd0, bus.wvalid}, 32'd1);
      chk("wd_wdata_stable", bus.wdata, 32'hA5A50001);
      chk("wd_no_bready", {31'd0, bus.bready}, 32'd0);
    end
    @(negedge clk);
    chk("wd_w_done_bready", {30'd0, bus.wvalid, bus.bready}, 32'd1);
    wait_rsp();
    chk("wd_aw_edge", aw_cyc - n_edge, 32'd1);
    chk("wd_w_edge", w_cyc - n_edge, 32'd4);
    chk("wd_latency", {24'd0, rsp_latency}, 32'd5);
    w_delay = 0;

    // 4: SLVERR read passthrough
    r_resp_k = RESP_SLVERR; r_force = 1'b1; r_force_dat = 32'h12345678;
    issue(1'b0, 4'hC, 32'h0, 4'h0);
    wait_rsp();
    chk("slverr_resp", {30'd0, rsp_resp}, 32'd2);
    chk("slverr_rdata", rsp_rdata, 32'h12345678);
    @(negedge clk);
    chk("slverr_back_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    r_resp_k = RESP_OKAY; r_force = 1'b0;

    // 5: response backpressure with a pending command
    rsp_ready = 1'b0;
    issue(1'b0, 4'h4, 32'h0, 4'h0);
    wait_rsp();
    hs_snap = hs_cnt;
    cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata_stable", rsp_rdata, 32'hDEADBEEF);
      chk("bp_fields_stable", {21'd0, rsp_write, rsp_resp, rsp_latency}, 32'd2);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_no_axi", hs_cnt - hs_snap, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    @(negedge clk);
    chk("bp_next_accepted", {30'd0, bus.awvalid, cmd_ready}, 32'd2);
    chk("bp_next_awaddr", {28'd0, bus.awaddr}, 32'h0);
    cmd_valid = 1'b0;
    wait_rsp();
    chk("bp_next_rsp_write", {31'd0, rsp_write}, 32'd1);

    // 6: latency saturation
    ar_rdy = 1'b0;
    issue(1'b0, 4'h4, 32'h0, 4'h0);
    repeat (300) @(negedge clk);
    chk("sat_arvalid_held", {31'd0, bus.arvalid}, 32'd1);
    ar_rdy = 1'b1;
    wait_rsp();
    chk("sat_latency", {24'd0, rsp_latency}, 32'd255);
    chk("sat_rdata", rsp_rdata, 32'hDEADBEEF);

    // 7: reset mid-WR
    aw_rdy = 1'b0;
    issue(1'b1, 4'h0, 32'h11111111, 4'hF);
    @(negedge clk);
    chk("mid_wr_awvalid", {31'd0, bus.awvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valids", {26'd0, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; aw_rdy = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_latency", {24'd0, rsp_latency}, 32'd0);

    // 8: DECERR write after recovery
    b_resp_k = RESP_DECERR;
    issue(1'b1, 4'h0, 32'h22222222, 4'hF);
    wait_rsp();
    chk("decerr_resp", {30'd0, rsp_resp}, 32'd3);
    chk("decerr_rdata_zero", rsp_rdata, 32'd0);
    chk("decerr_latency", {24'd0, rsp_latency}, 32'd2);
    b_resp_k = RESP_OKAY;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
